var_node_update: RTL and testbench

VAR_NODE_UPDATE -- requirements
Module: var_node_update

---
 rtl/var_node_update.sv | 159 +++++++++++++++
 tb/tb_var_node_update.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/var_node_update.sv
// GF(q) LDPC variable-node update: accumulates the channel LLR with DEGREE
// check messages, then streams normalized extrinsic messages and a hard decision.
module var_node_update #(
    parameter int FIELD   = 3,
    parameter int LLR_BIT = 4,
    parameter int DEGREE  = 3
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       START,
    input  logic [FIELD*LLR_BIT-1:0]   CH_LLR,
    input  logic                       IN_VALID,
    output logic                       IN_READY,
    input  logic [FIELD*LLR_BIT-1:0]   IN_LLR,
    output logic                       OUT_VALID,
    input  logic                       OUT_READY,
    output logic [FIELD*LLR_BIT-1:0]   OUT_LLR,
    output logic [$clog2(FIELD)-1:0]   DECISION,
    output logic                       DEC_VALID,
    output logic                       BUSY
);

    localparam int ACC_BIT = LLR_BIT + $clog2(DEGREE + 1);
    localparam int EXT_BIT = ACC_BIT + 1;
    localparam int DEC_BIT = $clog2(FIELD);
    localparam int IDX_BIT = (DEGREE > 1) ? $clog2(DEGREE) : 1;
    localparam logic [IDX_BIT-1:0] LAST_IDX = IDX_BIT'(DEGREE - 1);
    localparam logic signed [EXT_BIT-1:0] SAT_MAX = EXT_BIT'((2 ** (LLR_BIT - 1)) - 1);
    localparam logic signed [EXT_BIT-1:0] SAT_MIN = EXT_BIT'(-(2 ** (LLR_BIT - 1)));

    typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

    state_t                     state;
    logic [FIELD*ACC_BIT-1:0]   acc;
    logic [FIELD*ACC_BIT-1:0]   acc_sum;
    logic [FIELD*LLR_BIT-1:0]   buffer [DEGREE];
    logic [IDX_BIT-1:0]         in_cnt;
    logic [IDX_BIT-1:0]         out_cnt;
    logic [FIELD*LLR_BIT-1:0]   first_msg;
    logic [FIELD*LLR_BIT-1:0]   next_msg;

    function automatic logic [FIELD*ACC_BIT-1:0] widen(input logic [FIELD*LLR_BIT-1:0] v);
        logic [FIELD*ACC_BIT-1:0] r;
        r = '0;
        for (int unsigned e = 0; e < FIELD; e++)
            r[e*ACC_BIT +: ACC_BIT] = ACC_BIT'($signed(v[e*LLR_BIT +: LLR_BIT]));
        return r;
    endfunction

    // Extrinsic = total minus own message, then normalized against element 0.
    function automatic logic [FIELD*LLR_BIT-1:0] extrinsic(
        input logic [FIELD*ACC_BIT-1:0] a,
        input logic [FIELD*LLR_BIT-1:0] m
    );
        logic [FIELD*LLR_BIT-1:0] r;
        logic signed [EXT_BIT-1:0] ext0;
        logic signed [EXT_BIT-1:0] ext_e;
        logic signed [EXT_BIT-1:0] diff;
        r    = '0;
        ext0 = EXT_BIT'($signed(a[0 +: ACC_BIT])) - EXT_BIT'($signed(m[0 +: LLR_BIT]));
        for (int unsigned e = 0; e < FIELD; e++) begin
            ext_e = EXT_BIT'($signed(a[e*ACC_BIT +: ACC_BIT]))
                  - EXT_BIT'($signed(m[e*LLR_BIT +: LLR_BIT]));
            diff  = ext_e - ext0;
            if (diff > SAT_MAX)
                r[e*LLR_BIT +: LLR_BIT] = SAT_MAX[LLR_BIT-1:0];
            else if (diff < SAT_MIN)
                r[e*LLR_BIT +: LLR_BIT] = SAT_MIN[LLR_BIT-1:0];
            else
                r[e*LLR_BIT +: LLR_BIT] = diff[LLR_BIT-1:0];
        end
        return r;
    endfunction

    function automatic logic [DEC_BIT-1:0] argmax(input logic [FIELD*ACC_BIT-1:0] a);
        logic [DEC_BIT-1:0]        best_i;
        logic signed [ACC_BIT-1:0] best;
        logic signed [ACC_BIT-1:0] cur;
        best_i = '0;
        best   = a[0 +: ACC_BIT];
        for (int unsigned e = 1; e < FIELD; e++) begin
            cur = a[e*ACC_BIT +: ACC_BIT];
            if (cur > best) begin
                best   = cur;
                best_i = DEC_BIT'(e);
            end
        end
        return best_i;
    endfunction

    always_comb begin
        acc_sum = '0;
        for (int unsigned e = 0; e < FIELD; e++)
            acc_sum[e*ACC_BIT +: ACC_BIT] = acc[e*ACC_BIT +: ACC_BIT]
                                          + ACC_BIT'($signed(IN_LLR[e*LLR_BIT +: LLR_BIT]));
        // Slot 0 is still being written when the frame's only message arrives.
        first_msg = (in_cnt == '0) ? IN_LLR : buffer[0];
        next_msg  = buffer[0];
        if (out_cnt != LAST_IDX)
            next_msg = buffer[out_cnt + IDX_BIT'(1)];
        IN_READY = (state == ACCUM);
        BUSY     = (state != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            acc       <= '0;
            in_cnt    <= '0;
            out_cnt   <= '0;
            OUT_VALID <= 1'b0;
            OUT_LLR   <= '0;
            DECISION  <= '0;
            DEC_VALID <= 1'b0;
            for (int unsigned j = 0; j < DEGREE; j++)
                buffer[j] <= '0;
        end else begin
            DEC_VALID <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        acc    <= widen(CH_LLR);
                        in_cnt <= '0;
                        state  <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (IN_VALID) begin
                        buffer[in_cnt] <= IN_LLR;
                        acc            <= acc_sum;
                        if (in_cnt == LAST_IDX) begin
                            state     <= EMIT;
                            out_cnt   <= '0;
                            OUT_VALID <= 1'b1;
                            OUT_LLR   <= extrinsic(acc_sum, first_msg);
                            DECISION  <= argmax(acc_sum);
                            DEC_VALID <= 1'b1;
                        end else begin
                            in_cnt <= in_cnt + IDX_BIT'(1);
                        end
                    end
                end
                EMIT: begin
                    if (OUT_VALID && OUT_READY) begin
                        if (out_cnt == LAST_IDX) begin
                            OUT_VALID <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            out_cnt <= out_cnt + IDX_BIT'(1);
                            OUT_LLR <= extrinsic(acc, next_msg);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_var_node_update.sv
// Randomized self-checking bench for var_node_update with a frame-level
// reference model and directed frames pinning known results.
module tb_var_node_update;

    localparam int F = 3;
    localparam int L = 4;
    localparam int D = 3;
    localparam int W = F * L;

    logic         CLK = 1'b0;
    logic         RST;
    logic         START;
    logic [W-1:0] CH_LLR;
    logic         IN_VALID;
    logic         IN_READY;
    logic [W-1:0] IN_LLR;
    logic         OUT_VALID;
    logic         OUT_READY = 1'b0;
    logic [W-1:0] OUT_LLR;
    logic [1:0]   DECISION;
    logic         DEC_VALID;
    logic         BUSY;

    var_node_update #(.FIELD(F), .LLR_BIT(L), .DEGREE(D)) dut (
        .CLK(CLK), .RST(RST), .START(START), .CH_LLR(CH_LLR),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_LLR(IN_LLR),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_LLR(OUT_LLR),
        .DECISION(DECISION), .DEC_VALID(DEC_VALID), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    int   checks = 0;
    int   errors = 0;
    bit   checking = 1'b0;
    int   ready_mode = 0;
    logic manual_ready = 1'b1;

    logic [W-1:0] seen_q[$];
    logic [1:0]   last_dec = '0;
    int           dec_cnt = 0;

    bit           m_collect = 1'b0;
    logic [W-1:0] m_ch = '0;
    logic [W-1:0] m_msgs[$];
    logic [W-1:0] exp_q[$];
    logic [1:0]   m_dec = '0;
    bit           m_pulse = 1'b0;
    logic [D*W-1:0] ms_tmp;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] pk(int a, int b, int c);
        return {L'(c), L'(b), L'(a)};
    endfunction

    function automatic int sx(logic [W-1:0] v, int e);
        logic signed [L-1:0] t;
        t = v[e*L +: L];
        return int'(t);
    endfunction

    function automatic int total(logic [W-1:0] ch, logic [D*W-1:0] ms, int e);
        int s;
        s = sx(ch, e);
        for (int j = 0; j < D; j++) s += sx(ms[j*W +: W], e);
        return s;
    endfunction

    function automatic logic [W-1:0] model_out(logic [W-1:0] ch, logic [D*W-1:0] ms, int k);
        int ext[F];
        int v;
        logic [W-1:0] r;
        for (int e = 0; e < F; e++) ext[e] = total(ch, ms, e) - sx(ms[k*W +: W], e);
        for (int e = 0; e < F; e++) begin
            v = ext[e] - ext[0];
            if (v > 7) v = 7;
            if (v < -8) v = -8;
            r[e*L +: L] = L'(v);
        end
        return r;
    endfunction

    function automatic logic [1:0] model_dec(logic [W-1:0] ch, logic [D*W-1:0] ms);
        int best;
        int bi;
        best = total(ch, ms, 0);
        bi = 0;
        for (int e = 1; e < F; e++)
            if (total(ch, ms, e) > best) begin
                best = total(ch, ms, e);
                bi = e;
            end
        return 2'(bi);
    endfunction

    function automatic logic [W-1:0] rand_vec();
        logic [W-1:0] r;
        for (int e = 0; e < F; e++)
            case ($urandom_range(0, 3))
                0: r[e*L +: L] = 4'h7;
                1: r[e*L +: L] = 4'h8;
                default: r[e*L +: L] = L'($urandom);
            endcase
        return r;
    endfunction

    // Frame-level reference: sample inputs before each edge, check, then advance.
    always @(negedge CLK) begin
        if (checking) begin
            chk("in_ready", IN_READY, m_collect);
            chk("busy", BUSY, m_collect || exp_q.size() != 0);
            chk("out_valid", OUT_VALID, exp_q.size() != 0);
            if (exp_q.size() != 0) chk("out_llr", OUT_LLR, exp_q[0]);
            chk("dec_valid", DEC_VALID, m_pulse);
            chk("decision", DECISION, m_dec);
            if (OUT_VALID && OUT_READY) seen_q.push_back(OUT_LLR);
            if (DEC_VALID) begin
                last_dec = DECISION;
                dec_cnt++;
            end
        end
        if (RST) begin
            m_collect = 1'b0;
            m_msgs.delete();
            exp_q.delete();
            m_dec = '0;
            m_pulse = 1'b0;
        end else begin
            m_pulse = 1'b0;
            if (m_collect) begin
                if (IN_VALID) begin
                    m_msgs.push_back(IN_LLR);
                    if (m_msgs.size() == D) begin
                        for (int j = 0; j < D; j++) ms_tmp[j*W +: W] = m_msgs[j];
                        for (int k = 0; k < D; k++) exp_q.push_back(model_out(m_ch, ms_tmp, k));
                        m_dec = model_dec(m_ch, ms_tmp);
                        m_pulse = 1'b1;
                        m_collect = 1'b0;
                    end
                end
            end else if (exp_q.size() != 0) begin
                if (OUT_READY) void'(exp_q.pop_front());
            end else if (START) begin
                m_ch = CH_LLR;
                m_msgs.delete();
                m_collect = 1'b1;
            end
        end
    end

    always @(posedge CLK) begin
        #2;
        case (ready_mode)
            0: OUT_READY = 1'b1;
            1: OUT_READY = 1'($urandom_range(0, 1));
            default: OUT_READY = manual_ready;
        endcase
    end

    task automatic start_frame(logic [W-1:0] ch);
        @(posedge CLK); #1;
        START = 1'b1;
        CH_LLR = ch;
        @(posedge CLK); #1;
        START = 1'b0;
        CH_LLR = W'($urandom);
    endtask

    task automatic feed(logic [W-1:0] m0, logic [W-1:0] m1, logic [W-1:0] m2,
                        bit gaps, bit noise, int stop);
        logic [W-1:0] m [3];
        int i = 0;
        int budget = 0;
        m = '{m0, m1, m2};
        while (i < stop && budget < 100) begin
            IN_VALID = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            IN_LLR = IN_VALID ? m[i] : W'($urandom);
            START = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge CLK);
            if (IN_VALID && IN_READY) i++;
            @(posedge CLK); #1;
            budget++;
        end
        if (i < stop) chk("feed_timeout", i, stop);
        IN_VALID = 1'b0;
        START = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (n < 200) begin
            @(negedge CLK);
            if (!BUSY && !m_collect && exp_q.size() == 0) break;
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: frame still busy after %0d cycles", n);
        end
    endtask

    task automatic do_reset(int n);
        @(posedge CLK); #1;
        RST = 1'b1;
        IN_VALID = 1'($urandom_range(0, 1));
        START = 1'b1;
        repeat (n) @(posedge CLK);
        #1;
        RST = 1'b0;
        IN_VALID = 1'b0;
        START = 1'b0;
    endtask

    task automatic run_frame(logic [W-1:0] ch, logic [W-1:0] m0, logic [W-1:0] m1, logic [W-1:0] m2);
        seen_q.delete();
        dec_cnt = 0;
        start_frame(ch);
        feed(m0, m1, m2, 1'b0, 1'b0, 3);
        drain();
    endtask

    task automatic expect_frame(logic [W-1:0] o0, logic [W-1:0] o1, logic [W-1:0] o2, logic [1:0] dec);
        chk("n_out", seen_q.size(), 3);
        if (seen_q.size() == 3) begin
            chk("out_k0", seen_q[0], o0);
            chk("out_k1", seen_q[1], o1);
            chk("out_k2", seen_q[2], o2);
        end
        chk("dec_value", last_dec, dec);
        chk("dec_pulses", dec_cnt, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] a0, a1, a2, ach;
        int mode;
        RST = 1'b1;
        START = 1'b0;
        IN_VALID = 1'b1;
        IN_LLR = W'($urandom);
        CH_LLR = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_out_valid", OUT_VALID, 0);
        chk("rst_out_llr", OUT_LLR, 0);
        chk("rst_decision", DECISION, 0);
        chk("rst_dec_valid", DEC_VALID, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_in_ready", IN_READY, 0);
        checking = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        IN_VALID = 1'b0;

        chk("model_k0", model_out(pk(0,2,-1), {pk(0,1,0), pk(0,-2,3), pk(0,1,1)}, 0), 12'h210);
        chk("model_k1", model_out(pk(0,2,-1), {pk(0,1,0), pk(0,-2,3), pk(0,1,1)}, 1), 12'h040);
        chk("model_dec", model_dec(pk(0,2,-1), {pk(0,1,0), pk(0,-2,3), pk(0,1,1)}), 2);
        chk("model_sat", model_out(pk(0,7,-8), {pk(0,7,-8), pk(0,7,-8), pk(0,7,-8)}, 2), 12'h870);

        run_frame(pk(0,2,-1), pk(0,1,1), pk(0,-2,3), pk(0,1,0));
        expect_frame(12'h210, 12'h040, 12'h310, 2'd2);
        run_frame('0, '0, '0, '0);
        expect_frame(12'h000, 12'h000, 12'h000, 2'd0);
        run_frame(pk(0,7,-8), pk(0,7,-8), pk(0,7,-8), pk(0,7,-8));
        expect_frame(12'h870, 12'h870, 12'h870, 2'd1);
        run_frame(pk(3,0,0), '0, '0, '0);
        expect_frame(12'hDD0, 12'hDD0, 12'hDD0, 2'd0);

        // Backpressure at k=1 with stray START pulses
        ready_mode = 2;
        manual_ready = 1'b1;
        seen_q.delete();
        dec_cnt = 0;
        start_frame(pk(0,2,-1));
        feed(pk(0,1,1), pk(0,-2,3), pk(0,1,0), 1'b0, 1'b1, 3);
        @(posedge CLK); #1;
        manual_ready = 1'b0;
        repeat (3) begin
            START = 1'b1;
            @(negedge CLK);
            chk("stall_valid", OUT_VALID, 1);
            chk("stall_llr", OUT_LLR, 12'h040);
            @(posedge CLK); #1;
        end
        START = 1'b0;
        manual_ready = 1'b1;
        drain();
        expect_frame(12'h210, 12'h040, 12'h310, 2'd2);
        ready_mode = 0;

        // Abort after two messages, then the same frame again
        seen_q.delete();
        dec_cnt = 0;
        start_frame(pk(0,2,-1));
        feed(pk(0,1,1), pk(0,-2,3), pk(0,1,0), 1'b0, 1'b0, 2);
        do_reset(1);
        repeat (4) @(negedge CLK);
        chk("abort_no_out", seen_q.size(), 0);
        chk("abort_no_dec", dec_cnt, 0);
        run_frame(pk(0,2,-1), pk(0,1,1), pk(0,-2,3), pk(0,1,0));
        expect_frame(12'h210, 12'h040, 12'h310, 2'd2);

        ready_mode = 1;
        for (int n = 0; n < 300; n++) begin
            ach = rand_vec();
            a0 = rand_vec();
            a1 = rand_vec();
            a2 = rand_vec();
            mode = $urandom_range(0, 9);
            start_frame(ach);
            if (mode == 0) begin
                feed(a0, a1, a2, 1'b1, 1'b1, $urandom_range(0, 2));
                do_reset($urandom_range(1, 2));
            end else begin
                feed(a0, a1, a2, 1'b1, 1'b1, 3);
                if (mode == 1) begin
                    repeat ($urandom_range(0, 2)) @(posedge CLK);
                    do_reset(1);
                end
            end
            drain();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
